// File: rtl/if0_pc_queue_if.sv
// IF0 handshake bundle: redirect/flush control, icache request, BPU lookup and the PC-queue output.
// master = the IF0 PC queue, slave = the surrounding pipeline/icache/BPU.
interface if0_pc_queue_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int QDEPTH      = 4
);
  logic                          redirect_valid;
  logic [31:0]                   redirect_pc;
  logic                          flush;
  logic                          req_valid;
  logic [31:0]                   req_addr;
  logic                          req_uncached;
  logic                          addr_ok;
  logic [31:0]                   bpu_pc;
  logic [FETCH_WIDTH-1:0]        bpu_taken;
  logic [FETCH_WIDTH-1:0]        bpu_slot_valid;
  logic [31:0]                   bpu_next_pc;
  logic                          out_valid;
  logic                          out_ready;
  logic [32+2*FETCH_WIDTH-1:0]   out_bus;
  logic [$clog2(QDEPTH):0]       q_count;
  logic [31:0]                   stall_cnt;

  modport master (
    input  redirect_valid, redirect_pc, flush, addr_ok,
    input  bpu_taken, bpu_slot_valid, bpu_next_pc, out_ready,
    output req_valid, req_addr, req_uncached, bpu_pc,
    output out_valid, out_bus, q_count, stall_cnt
  );

  modport slave (
    output redirect_valid, redirect_pc, flush, addr_ok,
    output bpu_taken, bpu_slot_valid, bpu_next_pc, out_ready,
    input  req_valid, req_addr, req_uncached, bpu_pc,
    input  out_valid, out_bus, q_count, stall_cnt
  );
endinterface

// File: rtl/if0_pc_queue.sv
// IF0 fetch-PC generator with a small FIFO of {slot_valid, taken, pc} entries feeding IF1.
// Optional full-stall performance counter enabled by defining IF0_PERF_CNT_EN.
module if0_pc_queue #(
  parameter logic [31:0] RESET_PC    = 32'h1c000000,
  parameter int          FETCH_WIDTH = 2,
  parameter int          QDEPTH      = 4
) (
  input  logic           clk,
  input  logic           rst,
  if0_pc_queue_if.master bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 32 + 2 * FETCH_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  logic [31:0]   pc_r;
  logic [EW-1:0] mem_r [QDEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          full_s;
  logic          empty_s;
  logic          req_valid_s;
  logic          push_s;
  logic          pop_s;
  logic [EW-1:0] entry_s;

  // Handshake decode; redirect and flush squash both queue operations.
  always_comb begin
    full_s      = 1'b0;
    empty_s     = 1'b1;
    req_valid_s = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    entry_s     = {bus.bpu_slot_valid, bus.bpu_taken, pc_r};
    if (count_r == FULL_CNT) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    if (count_r == {CW{1'b0}}) begin
      empty_s = 1'b1;
    end else begin
      empty_s = 1'b0;
    end
    if (!rst && !full_s && !bus.redirect_valid) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    if (req_valid_s && bus.addr_ok && !bus.flush) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (!rst && !empty_s && bus.out_ready && !bus.redirect_valid && !bus.flush) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // PC, pointers and occupancy; reset > redirect > flush > normal advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (bus.redirect_valid) begin
      pc_r     <= bus.redirect_pc;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (bus.flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        pc_r     <= bus.bpu_next_pc;
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents of empty slots are don't-care, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

`ifdef IF0_PERF_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles the queue sits full with no redirect/flush pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'h0;
    end else if (full_s && !bus.redirect_valid && !bus.flush &&
                 (stall_cnt_r != 32'hFFFFFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
`else
  assign bus.stall_cnt = 32'h0;
`endif

  assign bus.req_valid    = req_valid_s;
  assign bus.req_addr     = pc_r;
  assign bus.req_uncached = 1'b0;
  assign bus.bpu_pc       = pc_r;
  assign bus.out_valid    = !empty_s;
  assign bus.out_bus      = mem_r[rd_ptr_r];
  assign bus.q_count      = count_r;

endmodule

// File: tb/tb_if0_pc_queue.sv
// Directed bench for if0_pc_queue: queue-based reference model checked every cycle plus literal checkpoints.
module tb_if0_pc_queue;
  localparam int FW = 2;
  localparam int QD = 4;
  localparam int EW = 32 + 2 * FW;
  localparam logic [31:0] RPC = 32'h1c000000;
`ifdef IF0_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL3 = 32'd3;
`else
  localparam logic [31:0] EXP_STALL3 = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;

  if0_pc_queue_if #(.FETCH_WIDTH(FW), .QDEPTH(QD)) bif ();

  if0_pc_queue #(.RESET_PC(RPC), .FETCH_WIDTH(FW), .QDEPTH(QD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0]   m_pc = RPC;
  logic [EW-1:0] m_q[$];
  logic [31:0]   m_stall = 32'd0;
  bit            m_ok = 1'b0;
  logic [3:0]    pat = 4'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // BPU stimulus changes on the falling edge, always predicting sequential pc+8
  always @(negedge clk) begin
    pat = pat + 4'd1;
    bif.bpu_next_pc    = m_pc + 32'd8;
    bif.bpu_taken      = pat[1:0];
    bif.bpu_slot_valid = pat[3:2];
  end

  // Reference model: a plain FIFO plus a fetch PC
  always @(posedge clk) begin
    bit full;
    bit acc;
    bit pp;
    if (rst) begin
      m_pc = RPC;
      m_q.delete();
      m_stall = 32'd0;
      m_ok = 1'b1;
    end else begin
      full = (m_q.size() == QD);
`ifdef IF0_PERF_CNT_EN
      if (full && !bif.redirect_valid && !bif.flush && m_stall != 32'hFFFFFFFF) m_stall = m_stall + 32'd1;
`endif
      if (bif.redirect_valid) begin
        m_pc = bif.redirect_pc;
        m_q.delete();
      end else if (bif.flush) begin
        m_q.delete();
      end else begin
        acc = !full && bif.addr_ok;
        pp  = (m_q.size() != 0) && bif.out_ready;
        if (pp) void'(m_q.pop_front());
        if (acc) begin
          m_q.push_back({bif.bpu_slot_valid, bif.bpu_taken, m_pc});
          m_pc = bif.bpu_next_pc;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_ok) begin
      check("cmp_req_valid", 64'(bif.req_valid),
            64'(!rst && (m_q.size() < QD) && !bif.redirect_valid));
      check("cmp_req_addr", 64'(bif.req_addr), 64'(m_pc));
      check("cmp_bpu_pc", 64'(bif.bpu_pc), 64'(m_pc));
      check("cmp_uncached", 64'(bif.req_uncached), 64'd0);
      check("cmp_out_valid", 64'(bif.out_valid), 64'(m_q.size() != 0));
      check("cmp_q_count", 64'(bif.q_count), 64'(m_q.size()));
      check("cmp_stall", 64'(bif.stall_cnt), 64'(m_stall));
      if (m_q.size() != 0) check("cmp_out_bus", 64'(bif.out_bus), 64'(m_q[0]));
    end
  end

  initial begin
    rst = 1'b1;
    bif.redirect_valid = 1'b0;
    bif.redirect_pc = 32'h0;
    bif.flush = 1'b0;
    bif.addr_ok = 1'b0;
    bif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; bif.addr_ok = 1'b1; bif.out_ready = 1'b1;

    // sequential fetch, head follows one cycle later
    @(negedge clk);
    check("r034_req_valid", 64'(bif.req_valid), 64'd1);
    check("r036_addr0", 64'(bif.req_addr), 64'h1c000000);
    check("r036_empty", 64'(bif.q_count), 64'd0);
    @(negedge clk);
    check("r036_addr1", 64'(bif.req_addr), 64'h1c000008);
    check("r036_head0", 64'(bif.out_bus[31:0]), 64'h1c000000);
    @(negedge clk);
    check("r036_addr2", 64'(bif.req_addr), 64'h1c000010);
    check("r036_head1", 64'(bif.out_bus[31:0]), 64'h1c000008);
    check("r036_count", 64'(bif.q_count), 64'd1);
    #1;

    // fill to full with IF1 stalled
    bif.redirect_valid = 1'b1; bif.redirect_pc = 32'h1c000000; bif.out_ready = 1'b0;
    @(posedge clk); #1;
    bif.redirect_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("r037_full", 64'(bif.q_count), 64'd4);
    check("r037_req_valid", 64'(bif.req_valid), 64'd0);
    check("r037_pc_held", 64'(bif.req_addr), 64'h1c000020);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("r037_stall", 64'(bif.stall_cnt), 64'(EXP_STALL3));
    #1;

    // single pop while full, then push resumes, then wrap-around
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    bif.out_ready = 1'b0;
    @(negedge clk);
    check("r040_pop_only", 64'(bif.q_count), 64'd3);
    check("r040_pc_held", 64'(bif.req_addr), 64'h1c000020);
    @(negedge clk);
    check("r040_refill", 64'(bif.q_count), 64'd4);
    check("r040_pc_adv", 64'(bif.req_addr), 64'h1c000028);
    #1;
    bif.out_ready = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("r040_wrap_head", 64'(bif.out_bus[31:0]), 64'h1c000040);
    check("r040_wrap_count", 64'(bif.q_count), 64'd3);
    check("r040_wrap_pc", 64'(bif.req_addr), 64'h1c000058);
    #1;

    // icache refuses for 3 cycles
    bif.addr_ok = 1'b0; bif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("r041_req_valid", 64'(bif.req_valid), 64'd1);
    check("r041_pc", 64'(bif.req_addr), 64'h1c000058);
    check("r041_count", 64'(bif.q_count), 64'd3);
    #1;

    // flush with 3 entries keeps the PC, same-cycle push/pop ignored
    bif.redirect_valid = 1'b1; bif.redirect_pc = 32'h1c000000; bif.addr_ok = 1'b1;
    @(posedge clk); #1;
    bif.redirect_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bif.addr_ok = 1'b0;
    @(negedge clk);
    check("r039_pre_count", 64'(bif.q_count), 64'd3);
    check("r039_pre_pc", 64'(bif.req_addr), 64'h1c000018);
    #1;
    bif.flush = 1'b1; bif.addr_ok = 1'b1; bif.out_ready = 1'b1;
    @(posedge clk); #1;
    bif.flush = 1'b0; bif.addr_ok = 1'b0; bif.out_ready = 1'b0;
    @(negedge clk);
    check("r039_count", 64'(bif.q_count), 64'd0);
    check("r039_out_valid", 64'(bif.out_valid), 64'd0);
    check("r039_pc", 64'(bif.req_addr), 64'h1c000018);
    #1;

    // redirect with 2 entries, same-cycle push and pop ignored
    bif.addr_ok = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bif.redirect_valid = 1'b1; bif.redirect_pc = 32'h1c001000; bif.out_ready = 1'b1;
    @(posedge clk); #1;
    bif.redirect_valid = 1'b0; bif.out_ready = 1'b0;
    @(negedge clk);
    check("r038_count", 64'(bif.q_count), 64'd0);
    check("r038_out_valid", 64'(bif.out_valid), 64'd0);
    check("r038_pc", 64'(bif.req_addr), 64'h1c001000);
    @(negedge clk);
    check("r038_next_pc", 64'(bif.req_addr), 64'h1c001008);
    check("r038_head", 64'(bif.out_bus[31:0]), 64'h1c001000);
    #1;

    // reset overrides redirect and flush
    rst = 1'b1; bif.redirect_valid = 1'b1; bif.redirect_pc = 32'hdead0000; bif.flush = 1'b1;
    @(posedge clk); #1;
    check("r033_req_valid", 64'(bif.req_valid), 64'd0);
    rst = 1'b0; bif.redirect_valid = 1'b0; bif.flush = 1'b0;
    @(negedge clk);
    check("r033_pc", 64'(bif.req_addr), 64'(RPC));
    check("r033_count", 64'(bif.q_count), 64'd0);
    check("r033_stall", 64'(bif.stall_cnt), 64'd0);
    check("r033_req_valid1", 64'(bif.req_valid), 64'd1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
